local_bias_ctrl: RTL
====================

LOCAL_BIAS_CTRL -- requirements
Module: local_bias_ctrl

Interface
REQ-001 SETTLE_CYCLES, default 64: cycles between the pdb rise and bias_ready; legal range 1..1023.
REQ-002 FILT_CYCLES, default 4: consecutive supply_ok-low cycles that trigger a fault; legal range 1..15.
REQ-003 clk  input  1  block clock; all state changes on the rising edge.
REQ-004 rstb  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  request bias on (level).
REQ-006 supply_ok  input  1  vddana_1p8/vddana_0p8/vssana all within window.
REQ-007 atb_req  input  1  testbus select request (level, four-phase).
REQ-008 atb_sel  input  2  requested testbus mode; 00 off, 01 1p8, 10 0p8, 11 currents.
REQ-009 atb_ack  output  1  testbus request acknowledge.
REQ-010 pdb  output  1  power-down-bar to the bias cell; 1 = bias enabled.
REQ-011 atb_ena  output  2  testbus enable to the bias cell.
REQ-012 bias_ready  output  1  bias currents settled and valid.
REQ-013 fault  output  1  supply fault latched.
REQ-014 fault_cnt  output  8  count of FAULT entries since reset.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 The FSM SHALL have exactly four states: OFF, SETTLE, ON, FAULT.
REQ-017 OFF: pdb=0, bias_ready=0; when en=1 and supply_ok=1 on an edge, the FSM SHALL enter SETTLE and pdb SHALL be 1 after that edge.
REQ-018 The settle counter SHALL clear on SETTLE entry and increment each SETTLE cycle; at count SETTLE_CYCLES-1 the FSM SHALL enter ON on the next edge, so bias_ready rises exactly SETTLE_CYCLES edges after pdb rises.
REQ-019 ON: pdb=1, bias_ready=1.
REQ-020 In SETTLE or ON, en=0 SHALL return the FSM to OFF on the next edge: pdb=0, bias_ready=0, atb_ena=00, all updated on the same edge.
REQ-021 In SETTLE or ON, a filter counter SHALL count consecutive supply_ok=0 cycles and SHALL clear on any supply_ok=1 cycle.
REQ-022 When the filter counter reaches FILT_CYCLES, the FSM SHALL enter FAULT on that edge; a glitch shorter than FILT_CYCLES SHALL NOT affect any output.
REQ-023 If en=0 and a filter expiry occur on the same edge, FAULT SHALL win.
REQ-024 FAULT: pdb=0, bias_ready=0, atb_ena=00, fault=1; the FSM SHALL leave to OFF only on an edge with en=0, and fault SHALL clear on that edge.
REQ-025 fault_cnt SHALL increment by 1 on each FAULT entry and SHALL saturate at 255.
REQ-026 Handshake: when atb_req=1 and atb_ack=0, atb_sel SHALL be captured into the atb register and atb_ack SHALL assert on the next edge.
REQ-027 atb_ack SHALL hold 1 while atb_req=1 and SHALL clear on the first edge with atb_req=0; atb_sel SHALL be ignored while atb_ack=1.
REQ-028 Requests SHALL be accepted in every state; atb_ena SHALL equal the atb register only in ON and SHALL be 00 in all other states.
REQ-029 A capture during ON SHALL appear on atb_ena on the same edge that atb_ack asserts.
REQ-030 The atb register SHALL retain its value through OFF, SETTLE and FAULT, and SHALL drive atb_ena again on the next ON entry.

Reset
REQ-031 rstb=0 SHALL immediately, without a clock, force state OFF and the following outputs: pdb=0, bias_ready=0, atb_ena=00, atb_ack=0, fault=0, fault_cnt=0.
REQ-032 rstb=0 SHALL also clear the atb register, settle counter and filter counter.
REQ-033 Reset release SHALL be synchronized so the FSM leaves OFF no earlier than the second clk edge after the rstb rise.
REQ-034 Reset asserted mid-SETTLE or mid-ON SHALL drop pdb and bias_ready asynchronously.

Verification
REQ-035 SETTLE_CYCLES=64, en=1, supply_ok=1 after reset -> pdb rises at edge N, bias_ready rises at edge N+64.
REQ-036 In ON: atb_req=1 with atb_sel=11 -> atb_ack=1 and atb_ena=11 on the same edge; atb_req=0 -> atb_ack=0 next edge, atb_ena stays 11.
REQ-037 In ON: supply_ok low for 3 cycles -> no output change; low for 4 cycles -> FAULT: pdb=0, atb_ena=00, fault=1, fault_cnt=1.
REQ-038 In FAULT with en held 1 -> FSM stays in FAULT; en=0 -> OFF, fault=0; en=1 again -> SETTLE then ON, and atb_ena restores 11.
REQ-039 rstb pulsed low mid-SETTLE at count 30 -> pdb=0 immediately, all outputs reset; after release, a full 64-cycle settle occurs.
REQ-040 en=0 and a filter expiry on the same edge -> FAULT entered, fault_cnt incremented.

Source files
------------

// File: rtl/local_bias_ctrl.sv
// Bias-cell power sequencer: OFF/SETTLE/ON/FAULT FSM with supply-fault filtering
// and a four-phase analog testbus select handshake. All outputs are registered.
module local_bias_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned FILT_CYCLES   = 4
) (
    input  logic       clk_i,
    input  logic       rstb_i,
    input  logic       en_i,
    input  logic       supply_ok_i,
    input  logic       atb_req_i,
    input  logic [1:0] atb_sel_i,
    output logic       atb_ack_o,
    output logic       pdb_o,
    output logic [1:0] atb_ena_o,
    output logic       bias_ready_o,
    output logic       fault_o,
    output logic [7:0] fault_cnt_o
);

    localparam logic [1:0] StOff    = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StOn     = 2'd2;
    localparam logic [1:0] StFault  = 2'd3;

    localparam logic [9:0] SettleLast = 10'(SETTLE_CYCLES - 1);
    localparam logic [3:0] FiltLast   = 4'(FILT_CYCLES - 1);

    logic [1:0] rst_sync_q;
    logic [1:0] state_q, state_d;
    logic [9:0] settle_cnt_q, settle_cnt_d;
    logic [3:0] filt_cnt_q, filt_cnt_d;
    logic [1:0] atb_q, atb_d;
    logic       atb_ack_q, atb_ack_d;
    logic       pdb_q, pdb_d;
    logic [1:0] atb_ena_q, atb_ena_d;
    logic       bias_ready_q, bias_ready_d;
    logic       fault_q, fault_d;
    logic [7:0] fault_cnt_q, fault_cnt_d;
    logic       filt_expire;

    // The FSM may leave OFF only once the synchronized release has propagated.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign filt_expire = !supply_ok_i && (filt_cnt_q == FiltLast);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        filt_cnt_d   = '0;
        unique case (state_q)
            StOff: begin
                if (rst_sync_q[1] && en_i && supply_ok_i) begin
                    state_d      = StSettle;
                    settle_cnt_d = '0;
                end
            end
            StSettle, StOn: begin
                if (!supply_ok_i) filt_cnt_d = filt_cnt_q + 4'd1;
                // A filter expiry outranks a simultaneous en drop.
                if (filt_expire) begin
                    state_d = StFault;
                end else if (!en_i) begin
                    state_d = StOff;
                end else if (state_q == StSettle) begin
                    if (settle_cnt_q == SettleLast) begin
                        state_d = StOn;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 10'd1;
                    end
                end
            end
            StFault: begin
                if (!en_i) state_d = StOff;
            end
            default: state_d = StOff;
        endcase
    end

    always_comb begin
        atb_d     = atb_q;
        atb_ack_d = atb_ack_q;
        if (atb_req_i && !atb_ack_q) begin
            atb_d     = atb_sel_i;
            atb_ack_d = 1'b1;
        end else if (!atb_req_i) begin
            atb_ack_d = 1'b0;
        end
    end

    // Outputs decode the next state so they change on the same edge as the FSM.
    always_comb begin
        pdb_d        = (state_d == StSettle) || (state_d == StOn);
        bias_ready_d = (state_d == StOn);
        atb_ena_d    = (state_d == StOn) ? atb_d : 2'b00;
        fault_d      = (state_d == StFault);
        fault_cnt_d  = fault_cnt_q;
        if ((state_d == StFault) && (state_q != StFault) && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_d = fault_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_q      <= StOff;
            settle_cnt_q <= '0;
            filt_cnt_q   <= '0;
            atb_q        <= '0;
            atb_ack_q    <= 1'b0;
            pdb_q        <= 1'b0;
            atb_ena_q    <= '0;
            bias_ready_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            filt_cnt_q   <= filt_cnt_d;
            atb_q        <= atb_d;
            atb_ack_q    <= atb_ack_d;
            pdb_q        <= pdb_d;
            atb_ena_q    <= atb_ena_d;
            bias_ready_q <= bias_ready_d;
            fault_q      <= fault_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    assign atb_ack_o    = atb_ack_q;
    assign pdb_o        = pdb_q;
    assign atb_ena_o    = atb_ena_q;
    assign bias_ready_o = bias_ready_q;
    assign fault_o      = fault_q;
    assign fault_cnt_o  = fault_cnt_q;

endmodule
